// File: rtl/ysyx_rob_pkg.sv
// Shared ROB definitions: default sizes, entry layout and tag/index helpers.
// Tag 0 means "no producer"; every live tag is its entry index plus one.
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 4
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

package ysyx_rob_pkg;
  localparam int unsigned DEF_ROB_SIZE = `YSYX_ROB_SIZE;
  localparam int unsigned DEF_XLEN     = `YSYX_XLEN;
  localparam int unsigned REG_LEN      = `YSYX_REG_LEN;
  localparam int unsigned ROB_IDX_W    = $clog2(DEF_ROB_SIZE);
  localparam int unsigned ROB_TAG_W    = ROB_IDX_W + 1;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic [REG_LEN-1:0]  rd;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] result;
    logic [DEF_XLEN-1:0] npc;
    logic                pc_change;
    logic                ebreak;
    logic                csr_wen;
    logic [11:0]         csr_addr;
    logic [DEF_XLEN-1:0] csr_wdata;
  } rob_entry_t;

  function automatic rob_idx_t tag_to_idx(input rob_tag_t tag);
    return rob_idx_t'(tag - 1'b1);
  endfunction

  function automatic rob_tag_t idx_to_tag(input rob_idx_t idx);
    return rob_tag_t'({1'b0, idx}) + 1'b1;
  endfunction
endpackage

// File: rtl/ysyx_rob_if.sv
// EXU writeback pipe into the ROB; the producer drives, the ROB listens.
interface exu_pipe_if #(
  parameter int unsigned TAG_W = 3,
  parameter int unsigned XLEN  = 32
);
  logic             valid;
  logic [TAG_W-1:0] dest;
  logic [XLEN-1:0]  result;
  logic [XLEN-1:0]  npc;
  logic             pc_change;
  logic             ebreak;
  logic             csr_wen;
  logic [11:0]      csr_addr;
  logic [XLEN-1:0]  csr_wdata;

  modport master (output valid, dest, result, npc, pc_change, ebreak, csr_wen, csr_addr, csr_wdata);
  modport slave  (input  valid, dest, result, npc, pc_change, ebreak, csr_wen, csr_addr, csr_wdata);
  modport out    (output valid, dest, result, npc, pc_change, ebreak, csr_wen, csr_addr, csr_wdata);
  modport in     (input  valid, dest, result, npc, pc_change, ebreak, csr_wen, csr_addr, csr_wdata);
endinterface

// File: rtl/ysyx_rob_lookup.sv
// One operand-tag lookup port; a same-cycle writeback to the tag wins over the entry.
module ysyx_rob_lookup #(
  parameter int unsigned TAG_W = 3,
  parameter int unsigned XLEN  = 32
) (
  input  logic [TAG_W-1:0] tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_dest,
  input  logic [XLEN-1:0]  wb_result,
  input  logic             ent_done,
  input  logic [XLEN-1:0]  ent_result,
  output logic             ready,
  output logic [XLEN-1:0]  data
);
  always_comb begin
    ready = 1'b1;
    data  = '0;
    if (tag != '0) begin
      if (wb_valid && (wb_dest == tag)) begin
        data = wb_result;
      end else begin
        ready = ent_done;
        data  = ent_result;
      end
    end
  end
endmodule

// File: rtl/ysyx_rob.sv
// In-order reorder buffer: allocates tags at dispatch, collects out-of-order
// writebacks, and retires one instruction per cycle with flush/halt handling.
module ysyx_rob import ysyx_rob_pkg::*; #(
  parameter int unsigned ROB_SIZE = `YSYX_ROB_SIZE,
  parameter int unsigned XLEN     = `YSYX_XLEN,
  parameter int unsigned TAG_W    = $clog2(ROB_SIZE) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [`YSYX_REG_LEN-1:0] disp_rd,
  input  logic [XLEN-1:0]          disp_pc,
  output logic [TAG_W-1:0]         disp_tag,
  exu_pipe_if.in                   exu,
  input  logic [TAG_W-1:0]         q1_tag,
  input  logic [TAG_W-1:0]         q2_tag,
  output logic                     q1_ready,
  output logic                     q2_ready,
  output logic [XLEN-1:0]          q1_data,
  output logic [XLEN-1:0]          q2_data,
  output logic                     cm_valid,
  output logic [`YSYX_REG_LEN-1:0] cm_rd,
  output logic [XLEN-1:0]          cm_data,
  output logic [TAG_W-1:0]         cm_tag,
  output logic [XLEN-1:0]          cm_pc,
  output logic                     cm_csr_wen,
  output logic [11:0]              cm_csr_addr,
  output logic [XLEN-1:0]          cm_csr_wdata,
  output logic                     flush,
  output logic [XLEN-1:0]          flush_npc,
  output logic                     halt
);
  localparam int unsigned IDX_W = $clog2(ROB_SIZE);

  rob_entry_t       entries [ROB_SIZE];
  logic [IDX_W-1:0] head, tail;
  logic [TAG_W-1:0] count;
  rob_entry_t       head_e, q1_e, q2_e;
  logic [IDX_W-1:0] wb_idx;
  logic             disp_fire, wb_hit, commit;

  assign head_e = entries[head];
  assign q1_e   = entries[tag_to_idx(q1_tag)];
  assign q2_e   = entries[tag_to_idx(q2_tag)];
  assign wb_idx = tag_to_idx(exu.dest);

  // Registered state only: a slot freed by this cycle's commit is not reusable yet,
  // and nothing is allocated while the redirect is being presented.
  assign disp_ready = (count != TAG_W'(ROB_SIZE)) && !halt && !flush;
  assign disp_tag   = idx_to_tag(tail);
  assign disp_fire  = disp_valid && disp_ready;
  assign wb_hit     = exu.valid && (exu.dest != '0) && entries[wb_idx].busy;
  assign commit     = !halt && head_e.busy && head_e.done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      cm_valid     <= 1'b0;
      cm_rd        <= '0;
      cm_data      <= '0;
      cm_tag       <= '0;
      cm_pc        <= '0;
      cm_csr_wen   <= 1'b0;
      cm_csr_addr  <= '0;
      cm_csr_wdata <= '0;
      flush        <= 1'b0;
      flush_npc    <= '0;
      halt         <= 1'b0;
    end else begin
      cm_valid   <= 1'b0;
      cm_csr_wen <= 1'b0;
      flush      <= 1'b0;

      if (disp_fire) begin
        entries[tail].busy <= 1'b1;
        entries[tail].done <= 1'b0;
        entries[tail].rd   <= disp_rd;
        entries[tail].pc   <= disp_pc;
        tail               <= tail + 1'b1;
      end

      if (wb_hit) begin
        entries[wb_idx].done      <= 1'b1;
        entries[wb_idx].result    <= exu.result;
        entries[wb_idx].npc       <= exu.npc;
        entries[wb_idx].pc_change <= exu.pc_change;
        entries[wb_idx].ebreak    <= exu.ebreak;
        entries[wb_idx].csr_wen   <= exu.csr_wen;
        entries[wb_idx].csr_addr  <= exu.csr_addr;
        entries[wb_idx].csr_wdata <= exu.csr_wdata;
      end

      if (commit) begin
        cm_valid           <= 1'b1;
        cm_rd              <= head_e.rd;
        cm_data            <= head_e.result;
        cm_tag             <= idx_to_tag(head);
        cm_pc              <= head_e.pc;
        cm_csr_wen         <= head_e.csr_wen;
        cm_csr_addr        <= head_e.csr_addr;
        cm_csr_wdata       <= head_e.csr_wdata;
        entries[head].busy <= 1'b0;
        head               <= head + 1'b1;
        if (head_e.ebreak) halt <= 1'b1;
        if (head_e.pc_change) begin
          flush     <= 1'b1;
          flush_npc <= head_e.npc;
        end
      end

      case ({disp_fire, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A redirect overrides every update above, including a same-cycle dispatch.
      if (commit && head_e.pc_change) begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
          entries[i].busy <= 1'b0;
          entries[i].done <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end
    end
  end

  ysyx_rob_lookup #(.TAG_W(TAG_W), .XLEN(XLEN)) u_q1 (
    .tag(q1_tag), .wb_valid(exu.valid), .wb_dest(exu.dest), .wb_result(exu.result),
    .ent_done(q1_e.done), .ent_result(q1_e.result), .ready(q1_ready), .data(q1_data)
  );

  ysyx_rob_lookup #(.TAG_W(TAG_W), .XLEN(XLEN)) u_q2 (
    .tag(q2_tag), .wb_valid(exu.valid), .wb_dest(exu.dest), .wb_result(exu.result),
    .ent_done(q2_e.done), .ent_result(q2_e.result), .ready(q2_ready), .data(q2_data)
  );
endmodule

// File: tb/tb_ysyx_rob.sv
// Directed bench for ysyx_rob (ROB_SIZE=4, XLEN=32); expected retires are queued
// at dispatch and checked by a monitor whenever cm_valid is presented.
module tb_ysyx_rob;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [4:0]  disp_rd = '0;
  logic [31:0] disp_pc = '0;
  logic [2:0]  disp_tag;
  logic [2:0]  q1_tag = '0, q2_tag = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        cm_valid, cm_csr_wen, flush, halt;
  logic [4:0]  cm_rd;
  logic [31:0] cm_data, cm_pc, cm_csr_wdata, flush_npc;
  logic [2:0]  cm_tag;
  logic [11:0] cm_csr_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] npc;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  exu_pipe_if #(.TAG_W(3), .XLEN(32)) exu ();

  ysyx_rob #(.ROB_SIZE(4), .XLEN(32), .TAG_W(3)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_tag(disp_tag), .exu(exu.in),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_data(cm_data), .cm_tag(cm_tag), .cm_pc(cm_pc),
    .cm_csr_wen(cm_csr_wen), .cm_csr_addr(cm_csr_addr), .cm_csr_wdata(cm_csr_wdata),
    .flush(flush), .flush_npc(flush_npc), .halt(halt)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every retire must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (cm_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got tag %0d expected no commit", cm_tag);
        end else begin
          mon_e = exp_q.pop_front();
          check("cm_tag", cm_tag, mon_e.tag);
          check("cm_rd", cm_rd, mon_e.rd);
          check("cm_data", cm_data, mon_e.data);
          check("cm_pc", cm_pc, mon_e.pc);
          check("cm_flush", flush, mon_e.flush);
          if (mon_e.flush) check("flush_npc", flush_npc, mon_e.npc);
          check("cm_csr_wen", cm_csr_wen, mon_e.csr_wen);
          if (mon_e.csr_wen) begin
            check("cm_csr_addr", cm_csr_addr, mon_e.csr_addr);
            check("cm_csr_wdata", cm_csr_wdata, mon_e.csr_wdata);
          end
        end
      end else begin
        check("flush_without_commit", flush, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [2:0] tag, input logic [4:0] rd, input logic [31:0] data,
                      input logic [31:0] pc, input logic fl = 1'b0, input logic [31:0] npc = '0,
                      input logic cw = 1'b0, input logic [11:0] ca = '0, input logic [31:0] cd = '0);
    exp_t e;
    e.tag = tag; e.rd = rd; e.data = data; e.pc = pc; e.flush = fl; e.npc = npc;
    e.csr_wen = cw; e.csr_addr = ca; e.csr_wdata = cd;
    exp_q.push_back(e);
  endtask

  task automatic disp(input logic [4:0] rd, input logic [31:0] pc, input logic [2:0] exp_tag);
    disp_valid = 1'b1;
    disp_rd    = rd;
    disp_pc    = pc;
    @(negedge clock);
    check("disp_ready_at_dispatch", disp_ready, 1'b1);
    check("disp_tag", disp_tag, exp_tag);
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic drive_wb(input logic [2:0] dest, input logic [31:0] result,
                          input logic pcc = 1'b0, input logic [31:0] npc = '0,
                          input logic ebr = 1'b0, input logic cw = 1'b0,
                          input logic [11:0] ca = '0, input logic [31:0] cd = '0);
    exu.valid = 1'b1; exu.dest = dest; exu.result = result; exu.npc = npc;
    exu.pc_change = pcc; exu.ebreak = ebr; exu.csr_wen = cw; exu.csr_addr = ca; exu.csr_wdata = cd;
  endtask

  task automatic clear_wb();
    exu.valid = 1'b0; exu.dest = '0; exu.result = '0; exu.npc = '0;
    exu.pc_change = 1'b0; exu.ebreak = 1'b0; exu.csr_wen = 1'b0; exu.csr_addr = '0; exu.csr_wdata = '0;
  endtask

  task automatic wb(input logic [2:0] dest, input logic [31:0] result,
                    input logic pcc = 1'b0, input logic [31:0] npc = '0,
                    input logic ebr = 1'b0, input logic cw = 1'b0,
                    input logic [11:0] ca = '0, input logic [31:0] cd = '0);
    drive_wb(dest, result, pcc, npc, ebr, cw, ca, cd);
    tick();
    clear_wb();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_disp_ready"}, disp_ready, 1'b1);
    check({tag, "_disp_tag"}, disp_tag, 3'd1);
    check({tag, "_cm_valid"}, cm_valid, 1'b0);
    check({tag, "_halt"}, halt, 1'b0);
    check({tag, "_flush"}, flush, 1'b0);
    check({tag, "_cm_csr_wen"}, cm_csr_wen, 1'b0);
    check({tag, "_cm_rd"}, cm_rd, 5'd0);
    check({tag, "_cm_data"}, cm_data, 32'd0);
    check({tag, "_flush_npc"}, flush_npc, 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    check({tag, "_drained"}, exp_q.size(), 0);
    disp_valid = 1'b0;
    clear_wb();
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    reset_checks(tag);
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    bit found;
    clear_wb();
    #1 reset = 1'b0;
    #1 reset_checks("por");
    @(negedge clock);
    reset = 1'b1;
    tick();

    // In-order retire of out-of-order results.
    disp(5'd5, 32'h8000_0000, 3'd1); push(3'd1, 5'd5, 32'h10, 32'h8000_0000);
    disp(5'd6, 32'h8000_0004, 3'd2); push(3'd2, 5'd6, 32'h20, 32'h8000_0004);
    disp(5'd7, 32'h8000_0008, 3'd3); push(3'd3, 5'd7, 32'h30, 32'h8000_0008);
    wb(3'd3, 32'h30);
    wb(3'd1, 32'h10);
    wb(3'd2, 32'h20);
    idle(6);

    // Full ROB: ready returns only the cycle after a commit, tag wraps to 1.
    apply_reset("rst_full");
    for (int i = 0; i < 4; i++) begin
      disp(5'(i + 1), 32'h100 + 32'(4 * i), 3'(i + 1));
      push(3'(i + 1), 5'(i + 1), 32'h111 * 32'(i + 1), 32'h100 + 32'(4 * i));
    end
    @(negedge clock);
    check("full_ready", disp_ready, 1'b0);
    check("full_tag_wrap", disp_tag, 3'd1);
    drive_wb(3'd1, 32'h111);
    tick();
    clear_wb();
    @(negedge clock);
    check("full_ready_commit_cycle", disp_ready, 1'b0);
    tick();
    @(negedge clock);
    check("full_ready_after_commit", disp_ready, 1'b1);
    check("full_tag_after_commit", disp_tag, 3'd1);
    tick();
    wb(3'd2, 32'h222);
    wb(3'd3, 32'h333);
    wb(3'd4, 32'h444);
    idle(6);

    // Redirect at tag 2; tag 3 is already done but must never retire.
    apply_reset("rst_flush");
    disp(5'd8, 32'h200, 3'd1);  push(3'd1, 5'd8, 32'h11, 32'h200);
    disp(5'd9, 32'h204, 3'd2);  push(3'd2, 5'd9, 32'h22, 32'h204, 1'b1, 32'h8000_0100);
    disp(5'd10, 32'h208, 3'd3);
    wb(3'd3, 32'h33);
    wb(3'd2, 32'h22, 1'b1, 32'h8000_0100);
    wb(3'd1, 32'h11);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (flush) begin
        found = 1'b1;
        break;
      end
    end
    check("flush_seen", found, 1'b1);
    check("flush_cycle_ready", disp_ready, 1'b0);
    disp_valid = 1'b1;
    disp_rd    = 5'd1;
    tick();
    disp_valid = 1'b0;
    @(negedge clock);
    check("flush_dispatch_dropped", disp_tag, 3'd1);
    tick();
    wb(3'd3, 32'h99);
    idle(5);

    // Lookup: writeback bypass and the tag-0 constant.
    apply_reset("rst_lookup");
    disp(5'd11, 32'h300, 3'd1); push(3'd1, 5'd11, 32'h1111, 32'h300);
    disp(5'd12, 32'h304, 3'd2); push(3'd2, 5'd12, 32'hABCD, 32'h304);
    q1_tag = 3'd2;
    q2_tag = 3'd0;
    @(negedge clock);
    check("q1_not_ready", q1_ready, 1'b0);
    tick();
    drive_wb(3'd2, 32'hABCD);
    @(negedge clock);
    check("q1_bypass_ready", q1_ready, 1'b1);
    check("q1_bypass_data", q1_data, 32'hABCD);
    check("q2_tag0_ready", q2_ready, 1'b1);
    check("q2_tag0_data", q2_data, 32'd0);
    tick();
    clear_wb();
    @(negedge clock);
    check("q1_entry_ready", q1_ready, 1'b1);
    check("q1_entry_data", q1_data, 32'hABCD);
    tick();
    q1_tag = 3'd0;
    wb(3'd1, 32'h1111);
    idle(6);

    // Ebreak retire with a CSR write: halt is sticky and blocks everything.
    apply_reset("rst_halt");
    disp(5'd13, 32'h400, 3'd1); push(3'd1, 5'd13, 32'h5, 32'h400, 1'b0, '0, 1'b1, 12'h305, 32'h1234);
    disp(5'd14, 32'h404, 3'd2);
    wb(3'd1, 32'h5, 1'b0, '0, 1'b1, 1'b1, 12'h305, 32'h1234);
    wb(3'd2, 32'h6);
    idle(4);
    @(negedge clock);
    check("halt_set", halt, 1'b1);
    check("halt_blocks_dispatch", disp_ready, 1'b0);
    idle(4);
    @(negedge clock);
    check("halt_sticky", halt, 1'b1);
    check("halt_cm_rd_held", cm_rd, 5'd13);
    apply_reset("rst_async");

    check("final_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
